// File: rtl/flag_register.sv
// Architectural {N,V,C,Z} flag register with LIFO shadow stack and registered branch-condition evaluation.
// Optional FLAG_FWD_EN: conditions see this cycle's next-state flags instead of the registered ones.
module flag_register #(
  parameter int STACK_DEPTH = 4,
  parameter int CNT_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  input  logic [2:0]       alu_op,
  input  logic             zero_in,
  input  logic             carry_in,
  input  logic             overflow_in,
  input  logic             result_msb,
  input  logic             flag_wr,
  input  logic [3:0]       flag_wdata,
  input  logic             push,
  input  logic             pop,
  input  logic             err_clr,
  input  logic             cond_req,
  input  logic [2:0]       cond_sel,
  output logic [3:0]       flags,
  output logic             cond_valid,
  output logic             cond_taken,
  output logic [CNT_W-1:0] stk_count,
  output logic             stk_err
);

  localparam int PTR_W = $clog2(STACK_DEPTH);

  logic [3:0]       stack_mem [STACK_DEPTH];
  logic [3:0]       flags_nxt;
  logic [3:0]       eval_flags;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] rd_idx;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;
  logic             err_set;
  logic             cond_res;

  // Depth is a power of two, so the count MSB alone marks "full" and the low bits are the write pointer.
  assign full    = stk_count[CNT_W-1];
  assign empty   = (stk_count == '0);
  assign wr_idx  = stk_count[PTR_W-1:0];
  assign rd_idx  = stk_count[PTR_W-1:0] - PTR_W'(1);
  assign do_push = push & ~pop & ~full;
  assign do_pop  = pop & ~push & ~empty;
  assign err_set = (push & pop) | (push & ~pop & full) | (pop & ~push & empty);

  always_comb begin
    flags_nxt = flags;
    if (alu_valid) begin
      case (alu_op)
        3'b000, 3'b001:         flags_nxt = {result_msb, overflow_in, carry_in, zero_in};
        3'b010, 3'b011, 3'b100: flags_nxt = {result_msb, flags[2], flags[1], zero_in};
        default:                flags_nxt = flags;
      endcase
    end
    if (flag_wr) flags_nxt = flag_wdata;
    if (do_pop)  flags_nxt = stack_mem[rd_idx];
  end

`ifdef FLAG_FWD_EN
  assign eval_flags = flags_nxt;
`else
  assign eval_flags = flags;
`endif

  always_comb begin
    cond_res = 1'b0;
    case (cond_sel)
      3'b000: cond_res = 1'b1;
      3'b001: cond_res = eval_flags[0];
      3'b010: cond_res = ~eval_flags[0];
      3'b011: cond_res = eval_flags[1];
      3'b100: cond_res = ~eval_flags[1];
      3'b101: cond_res = eval_flags[2];
      3'b110: cond_res = eval_flags[3];
      default: cond_res = (eval_flags[3] == eval_flags[2]);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags      <= 4'b0000;
      stk_count  <= '0;
      stk_err    <= 1'b0;
      cond_valid <= 1'b0;
      cond_taken <= 1'b0;
    end else begin
      flags      <= flags_nxt;
      cond_valid <= cond_req;
      cond_taken <= cond_req & cond_res;
      if (do_push)     stk_count <= stk_count + CNT_W'(1);
      else if (do_pop) stk_count <= stk_count - CNT_W'(1);
      // A fresh error outranks a same-cycle clear.
      if (err_set)      stk_err <= 1'b1;
      else if (err_clr) stk_err <= 1'b0;
    end
  end

  // Snapshot storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) stack_mem[wr_idx] <= flags;
  end

endmodule

// File: tb/tb_flag_register.sv
// Table-driven bench for flag_register with an expected-result queue, plus async-reset corner sequence.
module tb_flag_register;

  localparam int CNT_W = 3;
`ifdef FLAG_FWD_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             alu_valid, zero_in, carry_in, overflow_in, result_msb;
  logic [2:0]       alu_op;
  logic             flag_wr, push, pop, err_clr, cond_req;
  logic [3:0]       flag_wdata;
  logic [2:0]       cond_sel;
  logic [3:0]       flags;
  logic             cond_valid, cond_taken, stk_err;
  logic [CNT_W-1:0] stk_count;

  flag_register #(.STACK_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .alu_valid(alu_valid), .alu_op(alu_op),
    .zero_in(zero_in), .carry_in(carry_in), .overflow_in(overflow_in),
    .result_msb(result_msb), .flag_wr(flag_wr), .flag_wdata(flag_wdata),
    .push(push), .pop(pop), .err_clr(err_clr), .cond_req(cond_req),
    .cond_sel(cond_sel), .flags(flags), .cond_valid(cond_valid),
    .cond_taken(cond_taken), .stk_count(stk_count), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int av, op, z, c, v, n, fw, wd, pu, po, ec, cr, cs;
    int ef, ecnt, eerr, ecv, ect;
  } vec_t;

  typedef struct {
    int idx;
    logic [3:0] f;
    logic [CNT_W-1:0] cnt;
    logic err, cv, ct;
  } exp_t;

  vec_t tbl [32];
  exp_t exp_q [$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int idx, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", name, idx, got, want);
    end
  endtask

  task automatic drive_idle();
    alu_valid = 0; alu_op = 0; zero_in = 0; carry_in = 0; overflow_in = 0; result_msb = 0;
    flag_wr = 0; flag_wdata = 0; push = 0; pop = 0; err_clr = 0; cond_req = 0; cond_sel = 0;
  endtask

  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    alu_valid = 1'(v.av); alu_op = 3'(v.op); zero_in = 1'(v.z); carry_in = 1'(v.c);
    overflow_in = 1'(v.v); result_msb = 1'(v.n); flag_wr = 1'(v.fw); flag_wdata = 4'(v.wd);
    push = 1'(v.pu); pop = 1'(v.po); err_clr = 1'(v.ec); cond_req = 1'(v.cr); cond_sel = 3'(v.cs);
    e.idx = idx; e.f = 4'(v.ef); e.cnt = CNT_W'(v.ecnt);
    e.err = 1'(v.eerr); e.cv = 1'(v.ecv); e.ct = 1'(v.ect);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty vec=%0d got=0 want=1", idx);
    end else begin
      e = exp_q.pop_front();
      check("flags", e.idx, {4'b0, flags}, {4'b0, e.f});
      check("stk_count", e.idx, 8'(stk_count), 8'(e.cnt));
      check("stk_err", e.idx, {7'b0, stk_err}, {7'b0, e.err});
      check("cond_valid", e.idx, {7'b0, cond_valid}, {7'b0, e.cv});
      check("cond_taken", e.idx, {7'b0, cond_taken}, {7'b0, e.ct});
    end
  endtask

  initial begin
    //          av op z c v n fw wd  pu po ec cr cs   ef  cnt err cv ct
    tbl[0]  = '{1, 0, 0,1,1,0, 0, 0,  0, 0, 0, 0, 0,  6,  0, 0, 0, 0};
    tbl[1]  = '{1, 2, 1,0,0,0, 0, 0,  0, 0, 0, 0, 0,  7,  0, 0, 0, 0};
    tbl[2]  = '{1, 5, 0,0,0,1, 0, 0,  0, 0, 0, 0, 0,  7,  0, 0, 0, 0};
    tbl[3]  = '{0, 0, 0,0,0,0, 0, 0,  0, 0, 0, 1, 1,  7,  0, 0, 1, 1};
    tbl[4]  = '{0, 0, 0,0,0,0, 0, 0,  0, 0, 0, 1, 7,  7,  0, 0, 1, 0};
    tbl[5]  = '{0, 0, 0,0,0,0, 1, 1,  0, 0, 0, 0, 0,  1,  0, 0, 0, 0};
    tbl[6]  = '{0, 0, 0,0,0,0, 1, 2,  1, 0, 0, 0, 0,  2,  1, 0, 0, 0};
    tbl[7]  = '{0, 0, 0,0,0,0, 1, 3,  1, 0, 0, 0, 0,  3,  2, 0, 0, 0};
    tbl[8]  = '{0, 0, 0,0,0,0, 1, 4,  1, 0, 0, 0, 0,  4,  3, 0, 0, 0};
    tbl[9]  = '{0, 0, 0,0,0,0, 1, 5,  1, 0, 0, 0, 0,  5,  4, 0, 0, 0};
    tbl[10] = '{0, 0, 0,0,0,0, 1, 6,  1, 0, 0, 0, 0,  6,  4, 1, 0, 0};
    tbl[11] = '{1, 0, 1,0,0,0, 0, 0,  0, 1, 0, 0, 0,  4,  3, 1, 0, 0};
    tbl[12] = '{0, 0, 0,0,0,0, 1,15,  0, 1, 0, 0, 0,  3,  2, 1, 0, 0};
    tbl[13] = '{0, 0, 0,0,0,0, 0, 0,  0, 1, 0, 0, 0,  2,  1, 1, 0, 0};
    tbl[14] = '{0, 0, 0,0,0,0, 0, 0,  0, 1, 0, 0, 0,  1,  0, 1, 0, 0};
    tbl[15] = '{0, 0, 0,0,0,0, 0, 0,  0, 1, 0, 0, 0,  1,  0, 1, 0, 0};
    tbl[16] = '{0, 0, 0,0,0,0, 1, 9,  0, 1, 0, 0, 0,  9,  0, 1, 0, 0};
    tbl[17] = '{0, 0, 0,0,0,0, 0, 0,  0, 0, 1, 0, 0,  9,  0, 0, 0, 0};
    tbl[18] = '{1, 0, 0,1,0,1, 0, 0,  1, 1, 0, 0, 0, 10,  0, 1, 0, 0};
    tbl[19] = '{0, 0, 0,0,0,0, 0, 0,  1, 0, 1, 0, 0, 10,  1, 0, 0, 0};
    tbl[20] = '{0, 0, 0,0,0,0, 0, 0,  1, 1, 1, 0, 0, 10,  1, 1, 0, 0};
    tbl[21] = '{0, 0, 0,0,0,0, 0, 0,  0, 1, 0, 1, 6, 10,  0, 1, 1, 1};
    tbl[22] = '{0, 0, 0,0,0,0, 1, 0,  0, 0, 0, 0, 0,  0,  0, 1, 0, 0};
    tbl[23] = '{1, 1, 1,0,0,0, 0, 0,  0, 0, 0, 1, 1,  1,  0, 1, 1, FWD};
    tbl[24] = '{0, 0, 0,0,0,0, 0, 0,  0, 0, 0, 1, 0,  1,  0, 1, 1, 1};
    tbl[25] = '{0, 0, 0,0,0,0, 0, 0,  0, 0, 0, 1, 2,  1,  0, 1, 1, 0};
    tbl[26] = '{0, 0, 0,0,0,0, 1, 2,  0, 0, 0, 1, 3,  2,  0, 1, 1, FWD};
    tbl[27] = '{0, 0, 0,0,0,0, 0, 0,  0, 0, 0, 1, 4,  2,  0, 1, 1, 0};
    tbl[28] = '{0, 0, 0,0,0,0, 1, 4,  0, 0, 0, 1, 5,  4,  0, 1, 1, FWD};
    tbl[29] = '{0, 0, 0,0,0,0, 0, 0,  0, 0, 0, 0, 0,  4,  0, 1, 0, 0};
    tbl[30] = '{1, 3, 0,1,0,1, 0, 0,  0, 0, 0, 0, 0, 12,  0, 1, 0, 0};
    tbl[31] = '{1, 4, 1,0,0,0, 0, 0,  0, 0, 0, 0, 0,  5,  0, 1, 0, 0};

    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    check("reset_flags", -1, {4'b0, flags}, 8'h00);
    check("reset_count", -1, 8'(stk_count), 8'h00);
    check("reset_err", -1, {7'b0, stk_err}, 8'h00);
    check("reset_cv", -1, {7'b0, cond_valid}, 8'h00);
    check("reset_ct", -1, {7'b0, cond_taken}, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) apply(i, tbl[i]);

    // Reset landing while a condition result is on the outputs must cancel it at once.
    drive_idle();
    cond_req = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst_cv", 100, {7'b0, cond_valid}, 8'h01);
    cond_req = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_cv", 101, {7'b0, cond_valid}, 8'h00);
    check("mid_rst_ct", 101, {7'b0, cond_taken}, 8'h00);
    check("mid_rst_flags", 101, {4'b0, flags}, 8'h00);
    check("mid_rst_err", 101, {7'b0, stk_err}, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply(102, '{1, 0, 1,1,0,0, 0, 0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0});

    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flag_register.md
Name: flag_register

Overview:
- Sequential stage directly downstream of the ALU status logic.
- Latches the per-operation zero/carry/overflow outputs, plus the result sign bit, into the architectural flag register {N,V,C,Z}.
- Provides a LIFO shadow stack for interrupt entry and return.
- Evaluates branch conditions with a registered, 1-cycle-latency result for the control unit.

Parameters:
- STACK_DEPTH, 4: number of flag snapshots the shadow stack holds (power of two, ≥2).
- CNT_W, $clog2(STACK_DEPTH+1): width of the stack occupancy count (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- alu_valid  input  1  an ALU op completes this cycle; capture status.
- alu_op  input  3  opcode of the completing op: 000 ADD, 001 SUB, 010 INC, 011 DEC, 100 NEG, others = no arithmetic.
- zero_in  input  1  zero status from the ALU status logic.
- carry_in  input  1  carry status.
- overflow_in  input  1  overflow status.
- result_msb  input  1  bit 7 of the ALU result (negative).
- flag_wr  input  1  explicit flag load (SETF instruction).
- flag_wdata  input  4  {N,V,C,Z} to load on flag_wr.
- push  input  1  save current flags to the shadow stack (interrupt entry).
- pop  input  1  restore flags from the shadow stack (interrupt return).
- err_clr  input  1  clears stk_err.
- cond_req  input  1  branch condition evaluation request.
- cond_sel  input  3  condition code.
- flags  output  4  registered {N,V,C,Z}.
- cond_valid  output  1  pulses 1 cycle after cond_req.
- cond_taken  output  1  condition result; qualified by cond_valid.
- stk_count  output  CNT_W  current stack occupancy.
- stk_err  output  1  sticky overflow/underflow/conflict error.

Behaviour:
- Reset (async, rst=1): flags=4'b0000, stack pointer=0, stk_count=0, stk_err=0, cond_valid=0, cond_taken=0. Stack storage is not cleared.
- Reset mid-operation: everything above is forced immediately; any in-flight cond_valid is cancelled.
- Flag next-state priority, all updates registered on the rising edge: pop (valid) > flag_wr > alu_valid > hold.
- ALU update, ops 000 (ADD) and 001 (SUB): Z=zero_in, C=carry_in, V=overflow_in, N=result_msb.
- ALU update, ops 010/011/100 (INC/DEC/NEG): Z=zero_in, N=result_msb; C and V hold.
- ALU update, ops 101–111: no flag change.
- Push (pop=0): if stk_count<STACK_DEPTH, write the current registered flags (pre-update value of this cycle) at the pointer and increment. If full: no write, count unchanged, stk_err<=1.
- A same-cycle flag update still applies with push; the snapshot holds the old value.
- Pop (push=0): if stk_count>0, decrement and load flags from the new top entry; this overrides flag_wr and alu_valid in the same cycle. If empty: flags follow the normal priority (flag_wr/alu_valid), stk_err<=1.
- Push and pop in the same cycle: no stack change, stk_err<=1; flags follow flag_wr/alu_valid.
- stk_err is sticky until rst or err_clr. If err_clr and a new error occur in the same cycle, the error wins (stk_err=1).
- Conditions, evaluated on the registered flags at the cycle of cond_req (pre-update): 000 always; 001 EQ Z; 010 NE !Z; 011 CS C; 100 CC !C; 101 VS V; 110 MI N; 111 GE N==V.
- Condition latency: cond_valid=1 and cond_taken=result exactly one cycle after cond_req. Back-to-back requests give back-to-back results. When cond_valid=0, cond_taken=0.
- No combinational path exists from any input to any output.

Optional Feature:
- FLAG_FWD_EN defined: conditions are evaluated on the next-state flags (after pop/flag_wr/alu_valid resolution of the same cycle), so a branch directly following its compare sees the new flags. Output is still registered with 1-cycle latency.
- FLAG_FWD_EN undefined: conditions are evaluated on the pre-update registered flags, as above.

Test Plan:
- Reset then ADD: rst 1→0, alu_valid=1, alu_op=000, zero=0, carry=1, overflow=1, msb=0 → flags=4'b0110 next cycle; stk_count=0, stk_err=0.
- INC preserves C/V: from flags=4'b0110, INC with zero=1, msb=0 → flags=4'b0111.
- Stack fill and overflow: push 5 times (STACK_DEPTH=4) with distinct flags 1,2,3,4,5 → stk_count=4, stk_err=1. Four pops restore 4,3,2,1 in that order. A fifth pop leaves flags=1 and stk_err stays 1. err_clr → stk_err=0.
- Pop beats ALU: stack top=4'b1000, pop with alu_valid ADD (zero=1) in the same cycle → flags=4'b1000.
- Condition latency: flags=4'b0001, cond_req with cond_sel=001 → cond_valid=1, cond_taken=1 one cycle later. cond_sel=111 with flags N=1,V=0 → taken=0.
- Same-cycle compare+branch: flags=0, SUB with zero=1 and cond_req EQ simultaneously → taken=0 without FLAG_FWD_EN, taken=1 with it.
